ti_sbox_stage0: RTL and testbench

Front-end pipeline stage of the 2-share threshold-implementation S-box. Accepts one 2-shared state byte per handshake and maps each share independently through the linear GF(2^8)→GF((2^4)^2) isomorphism. Splits the result into the four nibble shares consumed by the Stage1 multiplier and registers them alongside three fresh 4-bit masks. The masks come from an internal xorshift PRNG. The output register is the TI glitch barrier in front of Stage1; the block also tracks 16-byte state frames.

---
 rtl/ti_sbox_stage0_pkg.sv | 39 +++
 rtl/ti_xorshift32.sv | 40 ++++
 rtl/ti_sbox_stage0.sv | 113 +++++++++++
 tb/tb_ti_sbox_stage0.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ti_sbox_stage0_pkg.sv
// Shared definitions for the 2-share TI S-box pipeline: the
// GF(2^8) -> GF((2^4)^2) isomorphism, the default PRNG seed and frame geometry.
package ti_sbox_stage0_pkg;

   localparam logic [31:0] DEFAULT_SEED = 32'h2463_4A5B;
   localparam int          FRAME_LEN    = 16;
   localparam int          NIBBLE_W     = 4;
   localparam int          CNT_W        = 4;

   // Isomorphism matrix over GF(2), one byte per output bit.
   // Row i (bits [8*i +: 8]) selects the input bits whose XOR forms output bit i.
   localparam logic [63:0] ISO_ROWS = {
      8'hA0,   // out bit 7
      8'hDE,   // out bit 6
      8'hAC,   // out bit 5
      8'hAE,   // out bit 4
      8'hC6,   // out bit 3
      8'h9E,   // out bit 2
      8'h52,   // out bit 1
      8'h43    // out bit 0
   };

   // Even/odd parity of a byte.
   function automatic logic parity8(input logic [7:0] v);
      return ^v;
   endfunction

   // Linear map of one share; applied to each share separately so no
   // cross-share term ever appears.
   function automatic logic [7:0] iso_map(input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         r[i] = parity8(ISO_ROWS[8*i +: 8] & b);
      end
      return r;
   endfunction

endpackage

// File: rtl/ti_xorshift32.sv
// 32-bit xorshift PRNG (shifts 13/17/5) with synchronous load.
// Load has priority over step; reset returns the state to SEED.
module ti_xorshift32
   import ti_sbox_stage0_pkg::*;
#(
   parameter logic [31:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   input  logic        load,
   input  logic [31:0] load_value,
   output logic [31:0] state
);

   logic [31:0] t1_s;
   logic [31:0] t2_s;
   logic [31:0] next_s;

   // One xorshift32 advance of the current state.
   always_comb begin
      t1_s   = state ^ (state << 5'd13);
      t2_s   = t1_s  ^ (t1_s  >> 5'd17);
      next_s = t2_s  ^ (t2_s  << 5'd5);
   end

   // State register: reset to seed, load wins over step, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (load) begin
         state <= load_value;
      end else if (step) begin
         state <= next_s;
      end else begin
         state <= state;
      end
   end

endmodule

// File: rtl/ti_sbox_stage0.sv
// Stage 0 of the 2-share TI S-box: maps each byte share through the field
// isomorphism, splits into nibble shares, attaches three fresh 4-bit masks
// and registers everything as the glitch barrier in front of Stage1.
// Optional build macro: TI_STAGE0_RESEED_EN adds seed_load/seed ports.
module ti_sbox_stage0
   import ti_sbox_stage0_pkg::*;
#(
   parameter logic [31:0] SEED = DEFAULT_SEED
) (
   input  logic                CLK,
   input  logic                RSTn,
`ifdef TI_STAGE0_RESEED_EN
   input  logic                seed_load,
   input  logic [31:0]         seed,
`endif
   input  logic [7:0]          in_a0,
   input  logic [7:0]          in_a1,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [NIBBLE_W-1:0] out_in00,
   output logic [NIBBLE_W-1:0] out_in01,
   output logic [NIBBLE_W-1:0] out_in10,
   output logic [NIBBLE_W-1:0] out_in11,
   output logic [NIBBLE_W-1:0] out_r0,
   output logic [NIBBLE_W-1:0] out_r1,
   output logic [NIBBLE_W-1:0] out_r2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last
);

   logic              accept_s;
   logic [7:0]        map0_s;
   logic [7:0]        map1_s;
   logic [31:0]       prng_state_s;
   logic              prng_load_s;
   logic [31:0]       prng_load_value_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              unused_prng_s;

   assign in_ready = ~out_valid | out_ready;
   assign accept_s = in_valid & in_ready;

   // Each share is mapped on its own.
   assign map0_s = iso_map(in_a0);
   assign map1_s = iso_map(in_a1);

`ifdef TI_STAGE0_RESEED_EN
   assign prng_load_s       = seed_load;
   assign prng_load_value_s = (seed == 32'h0000_0000) ? SEED : seed;
`else
   assign prng_load_s       = 1'b0;
   assign prng_load_value_s = SEED;
`endif

   // Only the low 12 bits feed the masks; the rest is PRNG-internal.
   assign unused_prng_s = ^prng_state_s[31:12];

   ti_xorshift32 #(
      .SEED       (SEED)
   ) u_prng (
      .clk        (CLK),
      .rst_n      (RSTn),
      .step       (accept_s),
      .load       (prng_load_s),
      .load_value (prng_load_value_s),
      .state      (prng_state_s)
   );

   // Frame position counter; a reseed restarts the frame.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (prng_load_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         cnt_r <= cnt_r + 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Output register: load on accept (masks from pre-update PRNG state),
   // clear valid on a plain drain, hold everything while stalled.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         out_in00  <= 4'h0;
         out_in01  <= 4'h0;
         out_in10  <= 4'h0;
         out_in11  <= 4'h0;
         out_r0    <= 4'h0;
         out_r1    <= 4'h0;
         out_r2    <= 4'h0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept_s) begin
         out_in00  <= map0_s[7:4];
         out_in01  <= map1_s[7:4];
         out_in10  <= map0_s[3:0];
         out_in11  <= map1_s[3:0];
         out_r0    <= prng_state_s[3:0];
         out_r1    <= prng_state_s[7:4];
         out_r2    <= prng_state_s[11:8];
         out_valid <= 1'b1;
         out_last  <= (cnt_r == CNT_W'(FRAME_LEN - 1));
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

endmodule

// File: tb/tb_ti_sbox_stage0.sv
// Self-checking bench for ti_sbox_stage0: directed steps with random data,
// checked against a behavioural model (column-table isomorphism, xorshift32
// arithmetic, frame count). Covers TI_STAGE0_RESEED_EN when defined.
module tb_ti_sbox_stage0;

   localparam logic [31:0] SEED = 32'h2463_4A5B;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic [7:0] in_a0 = 8'h00;
   logic [7:0] in_a1 = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] out_in00, out_in01, out_in10, out_in11;
   logic [3:0] out_r0, out_r1, out_r2;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_last;
`ifdef TI_STAGE0_RESEED_EN
   logic        seed_load = 1'b0;
   logic [31:0] seed = 32'h0;
`endif

   int tests = 0;
   int failed = 0;

   // model state
   logic [31:0] mx;
   int          mcnt;
   logic        ev, el;
   logic [3:0]  e00, e01, e10, e11, er0, er1, er2;

   always #5 CLK = ~CLK;

   ti_sbox_stage0 dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
`ifdef TI_STAGE0_RESEED_EN
      .seed_load (seed_load),
      .seed      (seed),
`endif
      .in_a0     (in_a0),
      .in_a1     (in_a1),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_in00  (out_in00),
      .out_in01  (out_in01),
      .out_in10  (out_in10),
      .out_in11  (out_in11),
      .out_r0    (out_r0),
      .out_r1    (out_r1),
      .out_r2    (out_r2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   // Isomorphism by linearity: XOR the images of the set input bits.
   function automatic logic [7:0] iso_ref(input logic [7:0] b);
      logic [7:0] cols [0:7];
      logic [7:0] r;
      cols = '{8'h01, 8'h5F, 8'h7C, 8'h74, 8'h46, 8'hB0, 8'h4B, 8'hFC};
      r = 8'h00;
      for (int j = 0; j < 8; j++) if (b[j]) r = r ^ cols[j];
      return r;
   endfunction

   function automatic logic [31:0] xs(input logic [31:0] x);
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      return x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mx = SEED; mcnt = 0; ev = 1'b0; el = 1'b0;
      e00 = 4'h0; e01 = 4'h0; e10 = 4'h0; e11 = 4'h0;
      er0 = 4'h0; er1 = 4'h0; er2 = 4'h0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_last"},  out_last,  1'b0);
      chk({tag, "_in00"},  out_in00,  4'h0);
      chk({tag, "_in01"},  out_in01,  4'h0);
      chk({tag, "_in10"},  out_in10,  4'h0);
      chk({tag, "_in11"},  out_in11,  4'h0);
      chk({tag, "_r0"},    out_r0,    4'h0);
      chk({tag, "_r1"},    out_r1,    4'h0);
      chk({tag, "_r2"},    out_r2,    4'h0);
   endtask

   task automatic check_outputs();
      chk("out_valid", out_valid, ev);
      if (ev) begin
         chk("out_last", out_last, el);
         chk("out_in00", out_in00, e00);
         chk("out_in01", out_in01, e01);
         chk("out_in10", out_in10, e10);
         chk("out_in11", out_in11, e11);
         chk("out_r0",   out_r0,   er0);
         chk("out_r1",   out_r1,   er1);
         chk("out_r2",   out_r2,   er2);
      end
   endtask

   // One clock: drive inputs, check in_ready, step model, check outputs.
   task automatic cycle(input logic v, input logic [7:0] a0, input logic [7:0] a1,
                        input logic ordy);
      logic       acc;
      logic [7:0] m0, m1;
      in_valid = v; in_a0 = a0; in_a1 = a1; out_ready = ordy;
      #1;
      chk("in_ready", in_ready, (!ev || ordy));
      acc = v && (!ev || ordy);
      @(posedge CLK); #1;
      if (acc) begin
         m0 = iso_ref(a0); m1 = iso_ref(a1);
         e00 = m0[7:4]; e01 = m1[7:4]; e10 = m0[3:0]; e11 = m1[3:0];
         er0 = mx[3:0]; er1 = mx[7:4]; er2 = mx[11:8];
         mx = xs(mx);
         el = (mcnt == 15);
         mcnt = (mcnt + 1) % 16;
         ev = 1'b1;
      end else if (ordy) begin
         ev = 1'b0;
      end
`ifdef TI_STAGE0_RESEED_EN
      if (seed_load) begin
         mx = (seed == 32'h0) ? SEED : seed;
         mcnt = 0;
      end
`endif
      check_outputs();
   endtask

   function automatic logic [7:0] rb();
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      logic [31:0] lastmask;
      int          vcount;
      logic [31:0] x1, x2;
      logic [7:0]  m;

      // ---- reset state
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check_zero("rst");
      chk("rst_in_ready", in_ready, 1'b1);
      RSTn = 1'b1;

      // ---- streaming 32 back-to-back, first byte carries the seed masks
      lastmask = 32'h0; vcount = 0;
      for (int i = 0; i < 32; i++) begin
         cycle(1'b1, rb(), rb(), 1'b1);
         if (i == 0) begin
            chk("seed_r0", out_r0, 4'hB);
            chk("seed_r1", out_r1, 4'h5);
            chk("seed_r2", out_r2, 4'hA);
         end
         if (out_last === 1'b1) lastmask[i] = 1'b1;
         if (out_valid === 1'b1) vcount++;
      end
      chk("stream_last_pos", lastmask, 32'h8000_8000);
      chk("stream_valid_cnt", vcount, 32);
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
      chk("drain_valid", out_valid, 1'b0);

      // ---- share correctness, both share positions
      m = iso_ref(8'h53);
      cycle(1'b1, 8'h53, 8'h00, 1'b1);
      chk("share0_hi", out_in00 ^ out_in01, m[7:4]);
      chk("share0_lo", out_in10 ^ out_in11, m[3:0]);
      cycle(1'b1, 8'h00, 8'h53, 1'b1);
      chk("share1_hi", out_in00 ^ out_in01, m[7:4]);
      chk("share1_lo", out_in10 ^ out_in11, m[3:0]);

      // ---- backpressure: fill, stall 5 cycles, release with same-cycle accept
      cycle(1'b1, rb(), rb(), 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, rb(), rb(), 1'b0);
         chk("stall_in_ready", in_ready, 1'b0);
      end
      cycle(1'b1, 8'hC3, 8'h3C, 1'b1);
      chk("release_valid", out_valid, 1'b1);
      m = iso_ref(8'hC3) ^ iso_ref(8'h3C);
      chk("release_byte", {out_in00 ^ out_in01, out_in10 ^ out_in11}, m);

      // ---- reset mid-stream (output register full)
      cycle(1'b1, rb(), rb(), 1'b0);
      RSTn = 1'b0;
      #1;
      check_zero("midrst");
      model_reset();
      @(posedge CLK); #1;
      RSTn = 1'b1;

      // ---- bubble 1,0,1: PRNG advances twice, frame counter at 2
      x1 = xs(SEED);
      x2 = xs(x1);
      cycle(1'b1, rb(), rb(), 1'b1);
      chk("bubble_first_r0", out_r0, SEED[3:0]);
      cycle(1'b0, rb(), rb(), 1'b1);
      cycle(1'b1, rb(), rb(), 1'b1);
      chk("bubble_second_r", {out_r2, out_r1, out_r0}, x1[11:0]);
      cycle(1'b1, rb(), rb(), 1'b1);
      chk("bubble_third_r", {out_r2, out_r1, out_r0}, x2[11:0]);
      for (int i = 0; i < 13; i++) begin
         cycle(1'b1, rb(), rb(), 1'b1);
         chk("bubble_frame_last", out_last, (i == 12));
      end

`ifdef TI_STAGE0_RESEED_EN
      // ---- reseed with zero behaves as default seed
      seed_load = 1'b1; seed = 32'h0;
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
      seed_load = 1'b0;
      cycle(1'b1, rb(), rb(), 1'b1);
      chk("reseed0_r", {out_r2, out_r1, out_r0}, SEED[11:0]);
      // ---- reseed to 1 during an accept: that byte keeps the old masks
      seed_load = 1'b1; seed = 32'h1;
      cycle(1'b1, rb(), rb(), 1'b1);
      seed_load = 1'b0;
      cycle(1'b1, rb(), rb(), 1'b1);
      chk("reseed1_r0", out_r0, 4'h1);
      chk("reseed1_r12", {out_r2, out_r1}, 8'h00);
      for (int i = 0; i < 15; i++) begin
         cycle(1'b1, rb(), rb(), 1'b1);
         chk("reseed_frame_last", out_last, (i == 14));
      end
`endif

      // ---- randomized traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), rb(), rb(), ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
